// File: rtl/rs232_pkg.sv
// Shared constants, FSM encoding and helpers for the RS-232 packet transmitter.
// Bit periods are counted in 50 MHz clk cycles.
`timescale 1ns/1ps
package rs232_pkg;

  localparam int unsigned CNT_W = 13;
  typedef logic [CNT_W-1:0] baud_t;

  localparam logic [7:0] STX = 8'h02;
  localparam logic [7:0] ETX = 8'h03;

  localparam baud_t BAUD_CNT_9600  = 13'd5208;
  localparam baud_t BAUD_CNT_19200 = 13'd2604;
  localparam baud_t BAUD_CNT_38400 = 13'd1302;

  localparam int          PAYLOAD_BYTES = 5;
  localparam logic [2:0]  LAST_BYTE     = 3'd7;
  localparam logic [3:0]  BIT_LAST_DATA = 4'd8;
  localparam logic [3:0]  BIT_STOP      = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  // Setting 3 is unused and falls back to the slowest rate.
  function automatic baud_t baud_decode(
    input logic [1:0] setting,
    input baud_t      cnt_9600,
    input baud_t      cnt_19200,
    input baud_t      cnt_38400
  );
    baud_t cnt;
    case (setting)
      2'd1:    cnt = cnt_19200;
      2'd2:    cnt = cnt_38400;
      default: cnt = cnt_9600;
    endcase
    return cnt;
  endfunction

  function automatic logic [7:0] frame_checksum(input logic [39:0] payload);
    logic [7:0] acc;
    acc = STX;
    for (int i = 0; i < PAYLOAD_BYTES; i++) begin
      acc = acc + payload[39-8*i -: 8];
    end
    return acc;
  endfunction

endpackage

// File: rtl/rs232_byte_tx.sv
// 8N1 byte serializer: a start request is taken while idle or in the last stop-bit
// cycle (o_done), so consecutive bytes abut with no gap. tx is a reset-to-1 flop.
`timescale 1ns/1ps
module rs232_byte_tx
  import rs232_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [7:0]       i_byte,
  input  logic [CNT_W-1:0] i_bit_max,
  output logic             o_done,
  output logic             o_tx
);

  logic             r_active;
  logic [3:0]       r_bit_idx;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_bit_max;
  logic [7:0]       r_shift;
  logic             r_tx;

  logic w_bit_end;
  logic w_last;
  logic w_take;

  assign w_bit_end = (r_cnt == r_bit_max);
  assign w_last    = r_active && w_bit_end && (r_bit_idx == BIT_STOP);
  assign w_take    = i_start && (!r_active || w_last);
  assign o_done    = w_last;
  assign o_tx      = r_tx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_active  <= 1'b0;
      r_bit_idx <= '0;
      r_cnt     <= '0;
      r_bit_max <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
    end else if (w_take) begin
      r_active  <= 1'b1;
      r_bit_idx <= '0;
      r_cnt     <= '0;
      r_bit_max <= i_bit_max;
      r_shift   <= i_byte;
      r_tx      <= 1'b0;
    end else if (r_active) begin
      if (w_bit_end) begin
        r_cnt <= '0;
        if (r_bit_idx == BIT_STOP) begin
          r_active  <= 1'b0;
          r_bit_idx <= '0;
          r_tx      <= 1'b1;
        end else begin
          r_bit_idx <= r_bit_idx + 4'd1;
          // Start and D0..D6 shift out the next data bit; leaving D7 enters the stop bit.
          if (r_bit_idx < BIT_LAST_DATA) begin
            r_tx    <= r_shift[0];
            r_shift <= {1'b0, r_shift[7:1]};
          end else begin
            r_tx <= 1'b1;
          end
        end
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  a_cnt_bound: assert property (@(posedge clk) disable iff (!rst)
    r_active |-> (r_cnt <= r_bit_max));

endmodule

// File: rtl/rs232_package_tx.sv
// Packet framer: STX, P0..P4, CHK, ETX sent back-to-back through rs232_byte_tx.
// STX starts the cycle after acceptance; a new request is also taken in the tx_done cycle.
`timescale 1ns/1ps
module rs232_package_tx
  import rs232_pkg::*;
#(
  parameter logic [CNT_W-1:0] BAUD_9600  = BAUD_CNT_9600,
  parameter logic [CNT_W-1:0] BAUD_19200 = BAUD_CNT_19200,
  parameter logic [CNT_W-1:0] BAUD_38400 = BAUD_CNT_38400
)(
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  buad_setting,
  input  logic        pkt_valid,
  input  logic [39:0] pkt_payload,
  output logic        pkt_ready,
  output logic        tx,
  output logic        busy,
  output logic        tx_done
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_armed;
  logic [2:0]       r_byte_idx;
  logic [2:0]       w_byte_idx_nxt;
  logic [39:0]      r_payload;
  logic [7:0]       r_chk;
  logic [CNT_W-1:0] r_bit_max;
  logic [CNT_W-1:0] w_bit_max;

  logic       w_accept;
  logic       w_byte_start;
  logic       w_byte_done;
  logic [7:0] w_byte;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_accept       = 1'b0;
    w_byte_start   = 1'b0;
    w_byte_idx_nxt = r_byte_idx;
    w_bit_max      = r_bit_max;
    w_byte         = STX;
    pkt_ready      = 1'b0;
    busy           = 1'b0;
    tx_done        = 1'b0;

    case (r_state)
      IDLE: begin
        pkt_ready = r_armed;
        w_accept  = pkt_valid && r_armed;
        if (w_accept) w_state_nxt = LOAD;
      end
      LOAD: begin
        busy        = 1'b1;
        w_state_nxt = SEND;
      end
      SEND: begin
        busy = 1'b1;
        if (w_byte_done) begin
          if (r_byte_idx == LAST_BYTE) begin
            w_state_nxt = DONE;
          end else begin
            w_byte_start   = 1'b1;
            w_byte_idx_nxt = r_byte_idx + 3'd1;
          end
        end
      end
      DONE: begin
        pkt_ready   = 1'b1;
        tx_done     = 1'b1;
        w_accept    = pkt_valid;
        w_state_nxt = pkt_valid ? LOAD : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase

    // STX is constant, so it goes out immediately while LOAD computes the checksum.
    if (w_accept) begin
      w_byte_start   = 1'b1;
      w_byte_idx_nxt = 3'd0;
      w_bit_max      = baud_decode(buad_setting, BAUD_9600, BAUD_19200, BAUD_38400)
                       - CNT_W'(1);
      w_byte         = STX;
    end else begin
      case (w_byte_idx_nxt)
        3'd1:    w_byte = r_payload[39:32];
        3'd2:    w_byte = r_payload[31:24];
        3'd3:    w_byte = r_payload[23:16];
        3'd4:    w_byte = r_payload[15:8];
        3'd5:    w_byte = r_payload[7:0];
        3'd6:    w_byte = r_chk;
        3'd7:    w_byte = ETX;
        default: w_byte = STX;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_armed    <= 1'b0;
      r_byte_idx <= '0;
      r_payload  <= '0;
      r_chk      <= '0;
      r_bit_max  <= '0;
    end else begin
      r_armed    <= 1'b1;
      r_byte_idx <= w_byte_idx_nxt;
      if (w_accept) begin
        r_payload <= pkt_payload;
        r_bit_max <= w_bit_max;
      end
      if (r_state == LOAD) begin
        r_chk <= frame_checksum(r_payload);
      end
    end
  end

  rs232_byte_tx u_byte_tx (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_byte_start),
    .i_byte    (w_byte),
    .i_bit_max (w_bit_max),
    .o_done    (w_byte_done),
    .o_tx      (tx)
  );

  a_done_ready: assert property (@(posedge clk) disable iff (!rst)
    tx_done |-> (pkt_ready && !busy));

endmodule
